// File: rtl/cpu_pkg.sv
// Purpose : shared encodings for the slt/sltu comparator arbiter and its core.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    SLT_IDLE = 2'd0,
    SLT_CALC = 2'd1,
    SLT_RESP = 2'd2
  } slt_state_e;

  // Comparison mode: signed slt or unsigned sltu
  localparam logic ALUC_SLT  = 1'b0;
  localparam logic ALUC_SLTU = 1'b1;

endpackage

// File: rtl/slt_core.sv
// Purpose : combinational slt/sltu comparator producing {0..0, less} plus both flags.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports   : a, b (WIDTH operands), aluc (0 = signed, 1 = unsigned) ->
//           c ({WIDTH-1 zeros, less}), carry (a <u b), negative (a <s b).
module slt_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             aluc,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             negative
);

  logic [WIDTH:0] diff_u;
  logic [WIDTH:0] diff_s;
  logic           less;

  always_comb begin
    // Zero-extend for the unsigned borrow, sign-extend for the signed compare.
    // The extra bit makes both subtractions overflow-free, so the top bit is
    // the exact sign of a-b (the WIDTH-bit MSB alone would be wrong on overflow).
    diff_u   = {1'b0, a} - {1'b0, b};
    diff_s   = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    carry    = diff_u[WIDTH];
    negative = diff_s[WIDTH];
    less     = (aluc == ALUC_SLTU) ? carry : negative;
    c        = {{(WIDTH-1){1'b0}}, less};
  end

endmodule

// File: rtl/slt_arbiter.sv
// Purpose : round-robin share of one slt/sltu comparator between two requesters.
// Latency : accept edge +1 -> rsp_valid; IDLE/CALC/RESP gives one op per 3 cycles.
// Backpressure: rsp held stable until rsp_ready; requests wait (ready low) while busy.
// Ports   : clk, rst_n (async active-low); reqX_valid/ready/a/b/aluc per requester;
//           rsp_valid/ready/id/c/carry/negative shared response; busy = not IDLE.
module slt_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_aluc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_aluc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_carry,
  output logic             rsp_negative,
  output logic             busy
);

  slt_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             aluc_q, aluc_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_negative_q, rsp_negative_d;
  logic             busy_q, busy_d;

  logic             gnt0, gnt1;
  logic [WIDTH-1:0] core_c;
  logic             core_carry, core_negative;

  slt_core #(.WIDTH(WIDTH)) u_core (
    .a        (a_q),
    .b        (b_q),
    .aluc     (aluc_q),
    .c        (core_c),
    .carry    (core_carry),
    .negative (core_negative)
  );

  always_comb begin
    // Round robin: on a tie the requester that did not win last time gets it.
    gnt0 = req0_valid && (!req1_valid || last_grant_q);
    gnt1 = req1_valid && (!req0_valid || !last_grant_q);

    // rst_n gating keeps ready low while reset is held, even though the
    // state register already reads IDLE.
    req0_ready = rst_n && (state_q == SLT_IDLE) && gnt0;
    req1_ready = rst_n && (state_q == SLT_IDLE) && gnt1;

    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    aluc_d         = aluc_q;
    id_d           = id_q;
    last_grant_d   = last_grant_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_c_d        = rsp_c_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_negative_d = rsp_negative_q;
    busy_d         = busy_q;

    case (state_q)
      SLT_IDLE: begin
        if (gnt0 || gnt1) begin
          a_d          = gnt1 ? req1_a    : req0_a;
          b_d          = gnt1 ? req1_b    : req0_b;
          aluc_d       = gnt1 ? req1_aluc : req0_aluc;
          id_d         = gnt1;
          last_grant_d = gnt1;
          state_d      = SLT_CALC;
          busy_d       = 1'b1;
        end
      end
      SLT_CALC: begin
        rsp_c_d        = core_c;
        rsp_carry_d    = core_carry;
        rsp_negative_d = core_negative;
        rsp_id_d       = id_q;
        rsp_valid_d    = 1'b1;
        state_d        = SLT_RESP;
      end
      SLT_RESP: begin
        // Data regs keep their values after the handshake; only rsp_valid drops.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = SLT_IDLE;
          busy_d      = 1'b0;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = SLT_IDLE;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= SLT_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      aluc_q         <= 1'b0;
      id_q           <= 1'b0;
      last_grant_q   <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_c_q        <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_negative_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      aluc_q         <= aluc_d;
      id_q           <= id_d;
      last_grant_q   <= last_grant_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_c_q        <= rsp_c_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_negative_q <= rsp_negative_d;
      busy_q         <= busy_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_c        = rsp_c_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_negative = rsp_negative_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_slt_arbiter.sv
// Purpose : directed self-checking bench for slt_arbiter.
// Latency : n/a.
// Backpressure: exercised by holding rsp_ready low in RESP.
module tb_slt_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid, req0_ready, req0_aluc;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_aluc;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_negative, busy;
  logic [W-1:0] rsp_c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  slt_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_aluc    (req0_aluc),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_aluc    (req1_aluc),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_c        (rsp_c),
    .rsp_carry    (rsp_carry),
    .rsp_negative (rsp_negative),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit id, input bit v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit aluc);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_aluc = aluc;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_aluc = aluc;
    end
  endtask

  // Call right after driving a request at a negedge; returns with ready seen high.
  task automatic wait_rdy(input bit id, input string tag);
    int n;
    n = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, ".ready_seen"}, (n < 20) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // One transaction with rsp_ready high; checks latency and response fields.
  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit aluc, input bit exp_less, input bit exp_cy,
                       input bit exp_neg, input string tag);
    @(negedge clk);
    set_req(id, 1'b1, a, b, aluc);
    wait_rdy(id, tag);
    @(posedge clk);
    #1 set_req(id, 1'b0, a, b, aluc);
    @(negedge clk);
    check({tag, ".calc_vld"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, ".calc_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, ".rsp_vld"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, ".rsp_id"}, {31'd0, rsp_id}, {31'd0, id});
    check({tag, ".rsp_c"}, rsp_c, {31'd0, exp_less});
    check({tag, ".carry"}, {31'd0, rsp_carry}, {31'd0, exp_cy});
    check({tag, ".negative"}, {31'd0, rsp_negative}, {31'd0, exp_neg});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, nrsp, cyc, last_acc;

    // 1. Reset with both requesters valid
    rsp_ready = 1'b1;
    set_req(0, 1'b1, '0, '0, 1'b0);
    set_req(1, 1'b1, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst.ready0", {31'd0, req0_ready}, 32'd0);
    check("rst.ready1", {31'd0, req1_ready}, 32'd0);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.rsp_c", rsp_c, 32'd0);
    req1_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst.first_ready0", {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b0;   // withdraw before the edge: nothing accepted

    // 2. Signed vs unsigned
    do_op(0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b1, "slt_neg");
    do_op(0, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, "sltu_neg");

    // 3. Overflow boundary and equality
    do_op(0, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, "ovf_slt");
    do_op(0, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b1, 1'b0, "ovf_sltu");
    do_op(1, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, "equal");

    // 4. Contention: last grant was requester 1, so 0 goes first
    @(negedge clk);
    set_req(0, 1'b1, 32'd1, 32'd2, 1'b0);   // less = 1
    set_req(1, 1'b1, 32'd5, 32'd3, 1'b0);   // less = 0
    acc = 0; nrsp = 0; cyc = 0; last_acc = -1;
    while (nrsp < 4 && cyc < 60) begin
      #1;
      if (req0_ready || req1_ready) begin
        check("cont.onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (last_acc >= 0) check("cont.spacing", cyc - last_acc, 32'd3);
        last_acc = cyc;
        acc++;
      end
      if (rsp_valid) begin
        check("cont.id", {31'd0, rsp_id}, nrsp % 2);
        check("cont.c", rsp_c, (nrsp % 2 == 0) ? 32'd1 : 32'd0);
        nrsp++;
      end
      @(posedge clk);
      #1;
      if (acc >= 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("cont.responses", nrsp, 32'd4);
    check("cont.accepts", acc, 32'd4);

    // 5. Backpressure
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'd3, 32'd9, 1'b1);
    wait_rdy(0, "bp0");
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 32'd3, 32'd9, 1'b1);
    set_req(1, 1'b1, 32'd2, 32'd10, 1'b0);
    @(negedge clk);
    check("bp.calc_ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    repeat (5) begin
      check("bp.hold_vld", {31'd0, rsp_valid}, 32'd1);
      check("bp.hold_id", {31'd0, rsp_id}, 32'd0);
      check("bp.hold_c", rsp_c, 32'd1);
      check("bp.hold_flags", {30'd0, rsp_carry, rsp_negative}, 32'd3);
      check("bp.hold_ready1", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp.idle_vld", {31'd0, rsp_valid}, 32'd0);
    check("bp.idle_busy", {31'd0, busy}, 32'd0);
    check("bp.idle_ready1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp.r1_vld", {31'd0, rsp_valid}, 32'd1);
    check("bp.r1_id", {31'd0, rsp_id}, 32'd1);
    check("bp.r1_c", rsp_c, 32'd1);

    // 6. Reset during CALC
    @(negedge clk);
    set_req(0, 1'b1, 32'd1, 32'd2, 1'b0);
    wait_rdy(0, "mid");
    @(posedge clk);
    #1 req0_valid = 1'b0;
    #1 rst_n = 1'b0;
    set_req(0, 1'b1, '0, '0, 1'b0);
    set_req(1, 1'b1, '0, '0, 1'b0);
    #1;
    check("mid.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid.busy", {31'd0, busy}, 32'd0);
    check("mid.readies", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("mid.rsp_c", rsp_c, 32'd0);
    check("mid.flags", {30'd0, rsp_carry, rsp_negative}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mid.no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    set_req(0, 1'b1, '0, '0, 1'b0);
    set_req(1, 1'b1, '0, '0, 1'b0);
    #1;
    check("mid.tie_ready0", {31'd0, req0_ready}, 32'd1);
    check("mid.tie_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid.after_vld", {31'd0, rsp_valid}, 32'd1);
    check("mid.after_id", {31'd0, rsp_id}, 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
